// File: rtl/instruction_fetch_pkg.sv
// Shared constants for the instruction fetch front end: FSM encoding,
// default reset vector, default ack timeout and the sequential PC step.
package instruction_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        HOLD  = 3'd3,
        FAULT = 3'd4
    } state_t;

    localparam logic [15:0] RESET_PC_DEFAULT    = 16'h0000;
    localparam int unsigned ACK_TIMEOUT_DEFAULT = 15;
    // Instructions are 16-bit words on a byte-addressed bus.
    localparam logic [15:0] PC_INC              = 16'd2;

endpackage

// File: rtl/instruction_fetch_timer.sv
// Saturating 8-bit wait counter used to bound how long a read may stay
// outstanding. Held at zero while clr is high, counts while en is high.
module fetch_timer #(
    parameter logic [7:0] LIMIT = 8'd15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] count_reg;

    // Clear has priority; the count sticks at 8'hFF rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= 8'd0;
        end else if (clr) begin
            count_reg <= 8'd0;
        end else if (en && (count_reg != 8'hFF)) begin
            count_reg <= count_reg + 8'd1;
        end
    end

    assign expired = (count_reg >= LIMIT);

endmodule

// File: rtl/instruction_fetch.sv
// Fetch front end: reads one 16-bit word per instruction over a req/ack
// handshake, presents it to the decoder with a one-cycle E strobe, then
// waits for the execute stage (Next) and follows taken branches.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic [15:0] MemAddr,
    output logic        MemRd,
    input  logic        MemAck,
    input  logic [15:0] MemData,
    input  logic        Next,
    input  logic        BrTaken,
    input  logic [15:0] BrTarget,
    output logic [15:0] Instr,
    output logic        E,
    output logic [15:0] PC,
    output logic        FLT
);

    localparam logic [7:0] ACK_LIMIT = 8'(ACK_TIMEOUT);

    state_t      state_reg, state_next;
    logic [15:0] fp_reg, fp_next;        // fetch pointer, drives MemAddr
    logic [15:0] pc_reg, pc_next;
    logic [15:0] instr_reg, instr_next;
    logic        memrd_reg, e_reg, flt_reg;
    logic        ack_expired;

    // The wait counter only runs while a read is outstanding, so it is
    // already zero on the first FETCH cycle.
    fetch_timer #(
        .LIMIT (ACK_LIMIT)
    ) u_timer (
        .clk     (Clock),
        .rst     (Reset),
        .clr     (state_reg != FETCH),
        .en      (state_reg == FETCH),
        .expired (ack_expired)
    );

    // Next-state and datapath updates; an ack in the expiring cycle still wins.
    always_comb begin
        state_next = state_reg;
        fp_next    = fp_reg;
        pc_next    = pc_reg;
        instr_next = instr_reg;
        case (state_reg)
            IDLE: state_next = FETCH;
            FETCH: begin
                if (MemAck) begin
                    instr_next = MemData;
                    pc_next    = fp_reg;
                    fp_next    = fp_reg + PC_INC;
                    state_next = ISSUE;
                end else if (ack_expired) begin
                    state_next = FAULT;
                end
            end
            ISSUE: state_next = HOLD;
            HOLD: begin
                if (Next) begin
                    if (BrTaken) begin
                        if (BrTarget[0]) begin
                            state_next = FAULT;
                        end else begin
                            fp_next    = BrTarget;
                            state_next = FETCH;
                        end
                    end else begin
                        state_next = FETCH;
                    end
                end
            end
            FAULT:   state_next = FAULT;
            default: state_next = FAULT;
        endcase
    end

    // State and registered outputs; strobes are decoded from the next state
    // so every output comes straight from a flop.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_reg <= IDLE;
            fp_reg    <= RESET_PC;
            pc_reg    <= RESET_PC;
            instr_reg <= 16'h0000;
            memrd_reg <= 1'b0;
            e_reg     <= 1'b0;
            flt_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            fp_reg    <= fp_next;
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            memrd_reg <= (state_next == FETCH);
            e_reg     <= (state_next == ISSUE);
            flt_reg   <= (state_next == FAULT);
        end
    end

    assign MemAddr = fp_reg;
    assign MemRd   = memrd_reg;
    assign Instr   = instr_reg;
    assign E       = e_reg;
    assign PC      = pc_reg;
    assign FLT     = flt_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: sequential fetch, branches, wrap,
// ack timeout, odd-target fault and asynchronous reset.
module tb_instruction_fetch;

    logic        Clock;
    logic        Reset;
    logic [15:0] MemAddr;
    logic        MemRd;
    logic        MemAck;
    logic [15:0] MemData;
    logic        Next;
    logic        BrTaken;
    logic [15:0] BrTarget;
    logic [15:0] Instr;
    logic        E;
    logic [15:0] PC;
    logic        FLT;

    int checks   = 0;
    int failures = 0;

    instruction_fetch #(
        .RESET_PC    (16'h0000),
        .ACK_TIMEOUT (15)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .MemAddr  (MemAddr),
        .MemRd    (MemRd),
        .MemAck   (MemAck),
        .MemData  (MemData),
        .Next     (Next),
        .BrTaken  (BrTaken),
        .BrTarget (BrTarget),
        .Instr    (Instr),
        .E        (E),
        .PC       (PC),
        .FLT      (FLT)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"}, MemAddr, 16'h0000);
        chk1({tag, "_rd"}, MemRd, 1'b0);
        chk({tag, "_instr"}, Instr, 16'h0000);
        chk1({tag, "_e"}, E, 1'b0);
        chk({tag, "_pc"}, PC, 16'h0000);
        chk1({tag, "_flt"}, FLT, 1'b0);
    endtask

    initial begin
        Reset = 1'b1; MemAck = 1'b0; MemData = 16'h0000;
        Next = 1'b0; BrTaken = 1'b0; BrTarget = 16'h0000;
        tick(); tick();
        chk_reset_vals("por");
        $display("step: power-on reset checked");

        // Release: FETCH at RESET_PC one cycle later
        Reset = 1'b0;
        tick();
        chk1("f0_rd", MemRd, 1'b1);
        chk("f0_addr", MemAddr, 16'h0000);
        MemAck = 1'b1; MemData = 16'h4C01;
        tick();                                  // ISSUE
        MemAck = 1'b0;
        chk1("i0_e", E, 1'b1);
        chk("i0_instr", Instr, 16'h4C01);
        chk("i0_pc", PC, 16'h0000);
        chk1("i0_rd", MemRd, 1'b0);
        tick();                                  // HOLD
        chk1("h0_e", E, 1'b0);
        Next = 1'b1;
        tick();                                  // FETCH @2
        Next = 1'b0;
        chk1("f1_rd", MemRd, 1'b1);
        chk("f1_addr", MemAddr, 16'h0002);
        MemAck = 1'b1; MemData = 16'h6123;
        tick();
        MemAck = 1'b0;
        chk1("i1_e", E, 1'b1);
        chk("i1_instr", Instr, 16'h6123);
        chk("i1_pc", PC, 16'h0002);
        tick();
        Next = 1'b1;
        tick();                                  // FETCH @4
        Next = 1'b0;
        chk("f2_addr", MemAddr, 16'h0004);
        $display("step: sequential fetch 0,2,4 checked");

        // Next/BrTaken during ISSUE are ignored; BrTaken alone is ignored
        MemAck = 1'b1; MemData = 16'h1111;
        tick();                                  // ISSUE
        MemAck = 1'b0;
        Next = 1'b1; BrTaken = 1'b1; BrTarget = 16'h0300;
        tick();                                  // HOLD (Next ignored)
        Next = 1'b0; BrTarget = 16'h0200;
        chk1("issue_next_ign_rd", MemRd, 1'b0);
        tick();                                  // still HOLD
        chk1("br_no_next_rd", MemRd, 1'b0);
        chk1("br_no_next_e", E, 1'b0);
        Next = 1'b1; BrTarget = 16'h0100;
        tick();                                  // FETCH @0x100
        Next = 1'b0; BrTaken = 1'b0;
        chk1("br_rd", MemRd, 1'b1);
        chk("br_addr", MemAddr, 16'h0100);
        MemAck = 1'b1; MemData = 16'h2222;
        tick();
        MemAck = 1'b0;
        chk1("br_e", E, 1'b1);
        chk("br_pc", PC, 16'h0100);
        chk("br_instr", Instr, 16'h2222);
        $display("step: taken branch to 0100 checked");

        // Wrap: branch to FFFE, then sequential to 0000
        tick();                                  // HOLD
        Next = 1'b1; BrTaken = 1'b1; BrTarget = 16'hFFFE;
        tick();
        Next = 1'b0; BrTaken = 1'b0;
        chk("wrap_addr0", MemAddr, 16'hFFFE);
        MemAck = 1'b1; MemData = 16'h3333;
        tick();
        MemAck = 1'b0;
        chk("wrap_pc", PC, 16'hFFFE);
        tick();
        Next = 1'b1;
        tick();
        Next = 1'b0;
        chk("wrap_addr1", MemAddr, 16'h0000);
        chk1("wrap_rd", MemRd, 1'b1);
        $display("step: address wrap checked");

        // Ack arriving in FETCH cycle 14: no fault
        for (int i = 0; i < 14; i++) tick();
        chk1("late_ack_pending_rd", MemRd, 1'b1);
        MemAck = 1'b1; MemData = 16'h4444;
        tick();
        MemAck = 1'b0;
        chk1("late_ack_flt", FLT, 1'b0);
        chk1("late_ack_e", E, 1'b1);
        chk("late_ack_instr", Instr, 16'h4444);
        tick();
        Next = 1'b1;
        tick();                                  // FETCH entry (cycle 0)
        Next = 1'b0;
        chk("to_addr", MemAddr, 16'h0002);
        $display("step: ack at cycle 14 checked");

        // Timeout: FLT rises 16 cycles after FETCH entry
        for (int i = 0; i < 15; i++) tick();
        chk1("to_c15_flt", FLT, 1'b0);
        tick();
        chk1("to_c16_flt", FLT, 1'b1);
        chk1("to_c16_rd", MemRd, 1'b0);
        $display("step: ack timeout checked");

        // Reset from FAULT, asynchronously
        #1 Reset = 1'b1;
        #1;
        chk_reset_vals("rst_flt");
        Reset = 1'b0;
        tick();
        chk1("rst1_rd", MemRd, 1'b1);
        // Reset while MemRd=1, with a late ack during reset
        #1 Reset = 1'b1;
        #1;
        chk1("rst_rd_rd", MemRd, 1'b0);
        chk("rst_rd_addr", MemAddr, 16'h0000);
        MemAck = 1'b1; MemData = 16'hDEAD;
        tick(); tick();
        chk("rst_late_ack_instr", Instr, 16'h0000);
        chk1("rst_late_ack_e", E, 1'b0);
        MemAck = 1'b0;
        Reset = 1'b0;
        tick();
        MemAck = 1'b1; MemData = 16'h5555;
        tick();
        MemAck = 1'b0;
        chk("pre_hold_instr", Instr, 16'h5555);
        tick();                                  // HOLD
        #1 Reset = 1'b1;
        #1;
        chk_reset_vals("rst_hold");
        Reset = 1'b0;
        $display("step: async reset during FETCH/HOLD checked");

        // Odd branch target faults
        tick();
        MemAck = 1'b1; MemData = 16'h6666;
        tick();
        MemAck = 1'b0;
        tick();                                  // HOLD
        Next = 1'b1; BrTaken = 1'b1; BrTarget = 16'h0101;
        tick();
        Next = 1'b0; BrTaken = 1'b0;
        chk1("odd_flt", FLT, 1'b1);
        chk1("odd_rd", MemRd, 1'b0);
        MemAck = 1'b1;
        tick(); tick(); tick();
        MemAck = 1'b0;
        chk1("odd_sticky_flt", FLT, 1'b1);
        chk1("odd_sticky_rd", MemRd, 1'b0);
        chk1("odd_sticky_e", E, 1'b0);
        #1 Reset = 1'b1;
        #1;
        chk1("odd_rst_flt", FLT, 1'b0);
        Reset = 1'b0;
        tick();
        chk1("odd_restart_rd", MemRd, 1'b1);
        chk("odd_restart_addr", MemAddr, 16'h0000);
        $display("step: odd target fault and recovery checked");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
